// File: rtl/cwp_window_ctrl.sv
// Register-window controller: owns CWP and WIM, sequences SAVE/RESTORE/WRCWP and
// resolves window conflicts by trapping, or by spill/fill when CWP_AUTOSPILL_EN is defined.
module cwp_window_ctrl #(
   parameter int NWIN = 8,
   localparam int CW = $clog2(NWIN)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            op_valid,
   output logic            op_ready,
   input  logic [1:0]      op_kind,
   input  logic [CW-1:0]   op_wdata,
   input  logic            wim_we,
   input  logic [NWIN-1:0] wim_wdata,
   output logic [CW-1:0]   cwp,
   output logic [CW-1:0]   cwp_p1,
   output logic [CW-1:0]   cwp_m1,
   output logic [NWIN-1:0] wim,
   output logic            trap_valid,
   output logic [1:0]      trap_kind,
   input  logic            trap_ack,
   output logic            xfer_req,
   output logic            xfer_dir,
   output logic [CW-1:0]   xfer_win,
   input  logic            xfer_done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_TRAP = 2'b01,
      ST_XFER = 2'b10
   } state_t;

   localparam logic [1:0] OP_SAVE    = 2'b01;
   localparam logic [1:0] OP_RESTORE = 2'b10;
   localparam logic [1:0] OP_WRCWP   = 2'b11;
   localparam logic [1:0] TK_NONE    = 2'b00;
   localparam logic [1:0] TK_OVF     = 2'b01;
   localparam logic [1:0] TK_UNF     = 2'b10;
   localparam logic [CW-1:0]   CW_ONE  = CW'(1'b1);
   localparam logic [NWIN-1:0] WIM_RST = NWIN'(2'b10);

   function automatic logic [NWIN-1:0] onehot(input logic [CW-1:0] idx);
      onehot = NWIN'(1'b1) << idx;
   endfunction

   state_t          state_r, state_n;
   logic [CW-1:0]   cwp_r, cwp_n;
   logic [NWIN-1:0] wim_r, wim_n;
   logic            trap_valid_r, trap_valid_n;
   logic [1:0]      trap_kind_r, trap_kind_n;
   logic [CW-1:0]   cwp_p1_s, cwp_m1_s, target_s;
   logic [NWIN-1:0] ewim_s;
   logic            conflict_s, restore_s;

   assign cwp_p1_s   = cwp_r + CW_ONE;
   assign cwp_m1_s   = cwp_r - CW_ONE;
   assign cwp        = cwp_r;
   assign cwp_p1     = cwp_p1_s;
   assign cwp_m1     = cwp_m1_s;
   assign wim        = wim_r;
   assign op_ready   = (state_r == ST_IDLE);
   assign trap_valid = trap_valid_r;
   assign trap_kind  = trap_kind_r;

`ifdef CWP_AUTOSPILL_EN
   logic            xfer_req_r, xfer_req_n;
   logic            xfer_dir_r, xfer_dir_n;
   logic [CW-1:0]   xfer_win_r, xfer_win_n;

   assign xfer_req = xfer_req_r;
   assign xfer_dir = xfer_dir_r;
   assign xfer_win = xfer_win_r;
`else
   logic            unused_xfer_done;

   assign unused_xfer_done = xfer_done;
   assign xfer_req = 1'b0;
   assign xfer_dir = 1'b0;
   assign xfer_win = '0;
`endif

   // Next-state logic: accepts ops in IDLE, waits for ack/done in TRAP/XFER
   always_comb begin
      state_n      = state_r;
      cwp_n        = cwp_r;
      wim_n        = wim_r;
      trap_valid_n = trap_valid_r;
      trap_kind_n  = trap_kind_r;
`ifdef CWP_AUTOSPILL_EN
      xfer_req_n   = xfer_req_r;
      xfer_dir_n   = xfer_dir_r;
      xfer_win_n   = xfer_win_r;
`endif
      ewim_s       = wim_we ? wim_wdata : wim_r;
      target_s     = cwp_m1_s;
      conflict_s   = 1'b0;
      restore_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            wim_n = ewim_s;
            if (op_valid) begin
               case (op_kind)
                  OP_SAVE: begin
                     target_s = cwp_m1_s;
                     if (ewim_s[cwp_m1_s]) begin
                        conflict_s = 1'b1;
                     end else begin
                        cwp_n = cwp_m1_s;
                     end
                  end
                  OP_RESTORE: begin
                     target_s  = cwp_p1_s;
                     restore_s = 1'b1;
                     if (ewim_s[cwp_p1_s]) begin
                        conflict_s = 1'b1;
                     end else begin
                        cwp_n = cwp_p1_s;
                     end
                  end
                  OP_WRCWP: cwp_n = op_wdata;
                  default:  cwp_n = cwp_r;
               endcase
               // A conflicting op is dropped for trap or parked for spill/fill
               if (conflict_s) begin
`ifdef CWP_AUTOSPILL_EN
                  state_n    = ST_XFER;
                  xfer_req_n = 1'b1;
                  xfer_dir_n = restore_s;
                  xfer_win_n = target_s;
`else
                  state_n      = ST_TRAP;
                  trap_valid_n = 1'b1;
                  trap_kind_n  = restore_s ? TK_UNF : TK_OVF;
`endif
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_TRAP: begin
            if (trap_ack) begin
               state_n      = ST_IDLE;
               trap_valid_n = 1'b0;
            end else begin
               state_n = ST_TRAP;
            end
         end
         ST_XFER: begin
`ifdef CWP_AUTOSPILL_EN
            if (xfer_done) begin
               wim_n      = onehot(xfer_dir_r ? (xfer_win_r + CW_ONE) : (xfer_win_r - CW_ONE));
               cwp_n      = xfer_win_r;
               xfer_req_n = 1'b0;
               state_n    = ST_IDLE;
            end else begin
               state_n = ST_XFER;
            end
`else
            state_n = ST_IDLE;
`endif
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         cwp_r        <= '0;
         wim_r        <= WIM_RST;
         trap_valid_r <= 1'b0;
         trap_kind_r  <= TK_NONE;
`ifdef CWP_AUTOSPILL_EN
         xfer_req_r   <= 1'b0;
         xfer_dir_r   <= 1'b0;
         xfer_win_r   <= '0;
`endif
      end else begin
         state_r      <= state_n;
         cwp_r        <= cwp_n;
         wim_r        <= wim_n;
         trap_valid_r <= trap_valid_n;
         trap_kind_r  <= trap_kind_n;
`ifdef CWP_AUTOSPILL_EN
         xfer_req_r   <= xfer_req_n;
         xfer_dir_r   <= xfer_dir_n;
         xfer_win_r   <= xfer_win_n;
`endif
      end
   end

endmodule

// File: tb/tb_cwp_window_ctrl.sv
// Bench for cwp_window_ctrl: directed steps plus random traffic against a
// cycle-level reference model built from the window rules (works with or without CWP_AUTOSPILL_EN).
module tb_cwp_window_ctrl;

   localparam int NWIN = 8;
   localparam int CW   = 3;

   logic            clk = 1'b0;
   logic            reset, op_valid, op_ready, wim_we, trap_valid, trap_ack;
   logic            xfer_req, xfer_dir, xfer_done;
   logic [1:0]      op_kind, trap_kind;
   logic [CW-1:0]   op_wdata, cwp, cwp_p1, cwp_m1, xfer_win;
   logic [NWIN-1:0] wim_wdata, wim;

   int n_cmp = 0;
   int n_err = 0;

   // model: state 0 idle, 1 trap, 2 xfer
   int m_cwp, m_st, m_tkind, m_xdir, m_xwin;
   logic [7:0] m_wim;

   cwp_window_ctrl #(.NWIN(NWIN)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .op_kind(op_kind), .op_wdata(op_wdata), .wim_we(wim_we), .wim_wdata(wim_wdata),
      .cwp(cwp), .cwp_p1(cwp_p1), .cwp_m1(cwp_m1), .wim(wim),
      .trap_valid(trap_valid), .trap_kind(trap_kind), .trap_ack(trap_ack),
      .xfer_req(xfer_req), .xfer_dir(xfer_dir), .xfer_win(xfer_win), .xfer_done(xfer_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("cwp", 32'(cwp), m_cwp);
      chk("cwp_p1", 32'(cwp_p1), (m_cwp + 1) % NWIN);
      chk("cwp_m1", 32'(cwp_m1), (m_cwp + NWIN - 1) % NWIN);
      chk("wim", 32'(wim), 32'(m_wim));
      chk("op_ready", 32'(op_ready), 32'(m_st == 0));
      chk("trap_valid", 32'(trap_valid), 32'(m_st == 1));
      chk("xfer_req", 32'(xfer_req), 32'(m_st == 2));
      if (m_st == 1) chk("trap_kind", 32'(trap_kind), m_tkind);
      if (m_st == 2) begin
         chk("xfer_dir", 32'(xfer_dir), m_xdir);
         chk("xfer_win", 32'(xfer_win), m_xwin);
      end
`ifndef CWP_AUTOSPILL_EN
      chk("xfer_dir_tied", 32'(xfer_dir), 0);
      chk("xfer_win_tied", 32'(xfer_win), 0);
`endif
   endtask

   // One clock: predict from current inputs, advance, then compare
   task automatic tick();
      int n_cwp, n_st, n_tkind, n_xdir, n_xwin, tgt, dir;
      logic [7:0] n_wim, ew;
      n_cwp = m_cwp; n_st = m_st; n_tkind = m_tkind; n_xdir = m_xdir; n_xwin = m_xwin; n_wim = m_wim;
      if (reset) begin
         n_cwp = 0; n_wim = 8'h02; n_st = 0; n_tkind = 0; n_xdir = 0; n_xwin = 0;
      end else if (m_st == 0) begin
         ew = wim_we ? wim_wdata : m_wim;
         n_wim = ew;
         if (op_valid && op_kind == 2'd3) n_cwp = int'(op_wdata);
         if (op_valid && (op_kind == 2'd1 || op_kind == 2'd2)) begin
            dir = (op_kind == 2'd2) ? 1 : 0;
            tgt = dir ? (m_cwp + 1) % NWIN : (m_cwp + NWIN - 1) % NWIN;
            if (!ew[tgt]) n_cwp = tgt;
            else begin
`ifdef CWP_AUTOSPILL_EN
               n_st = 2; n_xdir = dir; n_xwin = tgt;
`else
               n_st = 1; n_tkind = dir ? 2 : 1;
`endif
            end
         end
      end else if (m_st == 1) begin
         if (trap_ack) n_st = 0;
      end else begin
         if (xfer_done) begin
            n_wim = 8'h01 << ((m_xwin + (m_xdir != 0 ? 1 : NWIN - 1)) % NWIN);
            n_cwp = m_xwin;
            n_st = 0;
         end
      end
      @(posedge clk);
      #1;
      m_cwp = n_cwp; m_st = n_st; m_tkind = n_tkind; m_xdir = n_xdir; m_xwin = n_xwin; m_wim = n_wim;
      check_all();
   endtask

   task automatic clear_inputs();
      op_valid = 1'b0; op_kind = 2'd0; op_wdata = '0; wim_we = 1'b0; wim_wdata = '0;
      trap_ack = 1'b0; xfer_done = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      m_cwp = 0; m_st = 0; m_tkind = 0; m_xdir = 0; m_xwin = 0; m_wim = 8'h02;
      clear_inputs();
      reset = 1'b1;
      tick();
      do_reset();
      chk("rst_cwp", 32'(cwp), 0);
      chk("rst_cwp_p1", 32'(cwp_p1), 1);
      chk("rst_cwp_m1", 32'(cwp_m1), 7);
      chk("rst_wim", 32'(wim), 32'h02);
      chk("rst_ready", 32'(op_ready), 1);
      chk("rst_trap_kind", 32'(trap_kind), 0);
      chk("rst_xfer", {30'd0, xfer_req, xfer_dir}, 0);

      // back-to-back SAVEs
      op_valid = 1'b1; op_kind = 2'd1;
      tick(); chk("save1", 32'(cwp), 7);
      tick(); chk("save2", 32'(cwp), 6);
      tick(); chk("save3", 32'(cwp), 5); chk("save_ready", 32'(op_ready), 1);
      clear_inputs();

      // RESTORE into invalid window 1
      do_reset();
      op_valid = 1'b1; op_kind = 2'd2;
      tick();
      clear_inputs();
`ifdef CWP_AUTOSPILL_EN
      chk("fill_req", 32'(xfer_req), 1); chk("fill_dir", 32'(xfer_dir), 1); chk("fill_win", 32'(xfer_win), 1);
      chk("fill_ready", 32'(op_ready), 0);
      tick(); tick();
      xfer_done = 1'b1; tick(); xfer_done = 1'b0;
      chk("fill_cwp", 32'(cwp), 1); chk("fill_wim", 32'(wim), 32'h04); chk("fill_ready2", 32'(op_ready), 1);
`else
      chk("unf_valid", 32'(trap_valid), 1); chk("unf_kind", 32'(trap_kind), 2);
      chk("unf_cwp", 32'(cwp), 0); chk("unf_ready", 32'(op_ready), 0);
      tick(); tick(); tick();
      chk("unf_hold", 32'(trap_valid), 1);
      trap_ack = 1'b1; tick(); trap_ack = 1'b0;
      chk("unf_ack_ready", 32'(op_ready), 1); chk("unf_ack_cwp", 32'(cwp), 0);
`endif

      // cwp=2, wim=02, SAVE targets window 1
      do_reset();
      op_valid = 1'b1; op_kind = 2'd3; op_wdata = 3'd2;
      tick();
      op_kind = 2'd1;
      tick();
      clear_inputs();
`ifdef CWP_AUTOSPILL_EN
      chk("spill_req", 32'(xfer_req), 1); chk("spill_dir", 32'(xfer_dir), 0); chk("spill_win", 32'(xfer_win), 1);
      xfer_done = 1'b1; tick(); xfer_done = 1'b0;
      chk("spill_wim", 32'(wim), 32'h01); chk("spill_cwp", 32'(cwp), 1); chk("spill_ready", 32'(op_ready), 1);
`else
      chk("ovf_kind", 32'(trap_kind), 1); chk("ovf_cwp", 32'(cwp), 2);
      trap_ack = 1'b1; tick(); trap_ack = 1'b0;
`endif

      // RESTORE with a same-cycle WIM write that clears the conflict
      do_reset();
      op_valid = 1'b1; op_kind = 2'd2; wim_we = 1'b1; wim_wdata = 8'h80;
      tick();
      clear_inputs();
      chk("ewim_cwp", 32'(cwp), 1); chk("ewim_wim", 32'(wim), 32'h80); chk("ewim_trap", 32'(trap_valid), 0);

      // WRCWP then abort a conflict with reset
      op_valid = 1'b1; op_kind = 2'd3; op_wdata = 3'd5;
      tick();
      chk("wr_cwp", 32'(cwp), 5); chk("wr_p1", 32'(cwp_p1), 6); chk("wr_m1", 32'(cwp_m1), 4);
      op_kind = 2'd1; wim_we = 1'b1; wim_wdata = 8'h10;
      tick();
      clear_inputs();
      chk("abort_busy", 32'(op_ready), 0);
      do_reset();
      chk("abort_cwp", 32'(cwp), 0); chk("abort_wim", 32'(wim), 32'h02);
      chk("abort_ready", 32'(op_ready), 1); chk("abort_kind", 32'(trap_kind), 0);
      chk("abort_xfer", {29'd0, xfer_req, xfer_dir, trap_valid}, 0);
      chk("abort_win", 32'(xfer_win), 0);

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         reset     = ($urandom_range(63) == 0);
         op_valid  = ($urandom_range(3) != 0);
         op_kind   = 2'($urandom_range(3));
         op_wdata  = 3'($urandom_range(7));
         wim_we    = ($urandom_range(7) == 0);
         wim_wdata = ($urandom_range(1) == 0) ? 8'($urandom_range(255)) : (8'h01 << $urandom_range(7));
         trap_ack  = ($urandom_range(2) == 0);
         xfer_done = ($urandom_range(2) == 0);
         tick();
      end
      clear_inputs();
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
